rr_bus_arbiter: RTL

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter
//
// Purpose:
//   Round-robin arbiter that gives one of REQUESTER_COUNT burst sources
//   ownership of a single shared valid/ready bus. Ownership is won in IDLE,
//   with the search starting at the round-robin pointer. It is released by a
//   transfer carrying last, or by a forced release after MAX_BEATS transfers.
//   Every release is followed by one idle bubble cycle before the next grant.
//
// Parameters:
//   WIDTH            data bus width in bits
//   REQUESTER_COUNT  number of requesters (>= 2)
//   MAX_BEATS        beats per grant before forced release (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   per-requester beat valid
//   req_last   in   per-requester final beat of a burst
//   req_data   in   per-requester beat data (unpacked array)
//   req_ready  out  per-requester beat accepted (owner only)
//   out_valid  out  shared-bus beat valid
//   out_data   out  shared-bus beat data
//   out_last   out  shared-bus final beat
//   out_ready  in   shared-bus sink ready
//   grant      out  one-hot current owner, zero when idle
//   selection  out  index of current owner, zero when idle
// ---------------------------------------------------------------------------
module rr_bus_arbiter #(
    parameter int WIDTH           = 32,
    parameter int REQUESTER_COUNT = 4,
    parameter int MAX_BEATS       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [REQUESTER_COUNT-1:0]         req_valid,
    input  logic [REQUESTER_COUNT-1:0]         req_last,
    input  logic [WIDTH-1:0]                   req_data [REQUESTER_COUNT],
    output logic [REQUESTER_COUNT-1:0]         req_ready,
    output logic                               out_valid,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic [REQUESTER_COUNT-1:0]         grant,
    output logic [$clog2(REQUESTER_COUNT)-1:0] selection
);

    localparam int SEL_W  = $clog2(REQUESTER_COUNT);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   selection_q, selection_d;
    logic [SEL_W-1:0]   rrPtr_q, rrPtr_d;
    logic [BEAT_W-1:0]  beatCount_q, beatCount_d;

    logic               winnerFound;
    logic [SEL_W-1:0]   winnerIdx;
    int                 scanIdx;
    logic [SEL_W-1:0]   scanSel;

    logic               transfer;
    logic               releaseNow;

    // Winner search: scan downward in offset from the pointer so that the
    // smallest offset (the first set bit at or after rr_ptr, wrapping) is
    // the last one written and therefore wins.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        scanIdx     = 0;
        scanSel     = '0;
        for (int i = REQUESTER_COUNT - 1; i >= 0; i--) begin
            scanIdx = int'(rrPtr_q) + i;
            if (scanIdx >= REQUESTER_COUNT) begin
                scanIdx = scanIdx - REQUESTER_COUNT;
            end
            scanSel = SEL_W'(scanIdx);
            if (req_valid[scanSel]) begin
                winnerFound = 1'b1;
                winnerIdx   = scanSel;
            end
        end
    end

    // Next-state and output logic. While OWNED the owner's handshake is
    // passed straight through; every other requester sees req_ready low.
    // A release transfer returns to IDLE, which forms the bubble cycle.
    always_comb begin
        state_d     = state_q;
        selection_d = selection_q;
        rrPtr_d     = rrPtr_q;
        beatCount_d = beatCount_q;
        req_ready   = '0;
        grant       = '0;
        selection   = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        transfer    = 1'b0;
        releaseNow  = 1'b0;

        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d     = OWNED;
                    selection_d = winnerIdx;
                    beatCount_d = '0;
                end
            end

            OWNED: begin
                grant[selection_q]     = 1'b1;
                selection              = selection_q;
                out_valid              = req_valid[selection_q];
                out_data               = req_data[selection_q];
                out_last               = req_last[selection_q];
                req_ready[selection_q] = out_ready;

                transfer   = req_valid[selection_q] & out_ready;
                // beatCount_q counts earlier transfers, so MAX_BEATS-1 here
                // means this transfer is the MAX_BEATS-th of the grant.
                releaseNow = transfer &
                             (req_last[selection_q] |
                              (beatCount_q == BEAT_W'(MAX_BEATS - 1)));

                if (releaseNow) begin
                    state_d     = IDLE;
                    beatCount_d = '0;
                    if (selection_q == SEL_W'(REQUESTER_COUNT - 1)) begin
                        rrPtr_d = '0;
                    end else begin
                        rrPtr_d = selection_q + SEL_W'(1);
                    end
                end else if (transfer) begin
                    beatCount_d = beatCount_q + BEAT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears ownership immediately, which also
    // forces all outputs derived from the state to their idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            selection_q <= '0;
            rrPtr_q     <= '0;
            beatCount_q <= '0;
        end else begin
            state_q     <= state_d;
            selection_q <= selection_d;
            rrPtr_q     <= rrPtr_d;
            beatCount_q <= beatCount_d;
        end
    end

endmodule
